// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out deserializer with word sync, a one-deep valid/ready
// output register, and a sticky overflow flag for words dropped under backpressure.
module sipo_deserializer #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_in,
    input  logic             s_valid,
    input  logic             s_sync,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overflow,
    input  logic             clr_ovf,
    output logic             busy
);

    localparam int unsigned          CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] sh_shift;
    logic             complete;
    logic             drop;

    // Shift/count the serial side, then resolve the completed word against the output slot.
    always_comb begin
        sh_d       = sh_q;
        cnt_d      = cnt_q;
        p_out_d    = p_out_q;
        p_valid_d  = p_valid_q;
        overflow_d = overflow_q;
        complete   = 1'b0;
        drop       = 1'b0;

        if (MSB_FIRST) begin
            sh_shift = {sh_q[WIDTH-2:0], s_in};
        end else begin
            sh_shift = {s_in, sh_q[WIDTH-1:1]};
        end

        if (s_valid) begin
            sh_d = sh_shift;
            if (s_sync) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                complete = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (complete) begin
            if (!p_valid_q || p_ready) begin
                p_out_d   = sh_shift;
                p_valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end

        // A drop on the same edge as a clear leaves the flag set.
        if (clr_ovf) begin
            overflow_d = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q       <= '0;
            cnt_q      <= '0;
            p_out_q    <= '0;
            p_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            p_out_q    <= p_out_d;
            p_valid_q  <= p_valid_d;
            overflow_q <= overflow_d;
        end
    end

    assign p_out    = p_out_q;
    assign p_valid  = p_valid_q;
    assign overflow = overflow_q;
    assign busy     = (cnt_q != '0);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: directed scenarios plus randomized traffic checked
// against a queue-based word-assembly model, on MSB-first and LSB-first instances.
module tb_sipo_deserializer;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_in = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_sync = 1'b0;
    logic         p_ready = 1'b0;
    logic         clr_ovf = 1'b0;
    logic [W-1:0] p_out_m, p_out_l;
    logic         p_valid_m, p_valid_l;
    logic         overflow_m, overflow_l;
    logic         busy_m, busy_l;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: bits of the word in progress, the output slot, the overflow flag.
    bit           m_bits[$];
    logic [W-1:0] m_out_m, m_out_l;
    logic         m_valid, m_ovf;

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_sync(s_sync),
        .p_out(p_out_m), .p_valid(p_valid_m), .p_ready(p_ready),
        .overflow(overflow_m), .clr_ovf(clr_ovf), .busy(busy_m)
    );

    sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .s_in(s_in), .s_valid(s_valid), .s_sync(s_sync),
        .p_out(p_out_l), .p_valid(p_valid_l), .p_ready(p_ready),
        .overflow(overflow_l), .clr_ovf(clr_ovf), .busy(busy_l)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the edge, settle past the edge.
    task automatic step(input bit r, input bit sv, input bit si, input bit ss,
                        input bit rdy, input bit clr);
        logic [W-1:0] wm, wl;
        bit           done;
        bit           drop;
        rst = r; s_valid = sv; s_in = si; s_sync = ss; p_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        done = 1'b0;
        drop = 1'b0;
        wm   = '0;
        wl   = '0;
        if (r) begin
            m_bits.delete();
            m_out_m = '0; m_out_l = '0; m_valid = 1'b0; m_ovf = 1'b0;
        end else begin
            if (sv) begin
                if (ss) m_bits.delete();
                m_bits.push_back(si);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        wm[W-1-i] = m_bits[i];
                        wl[i]     = m_bits[i];
                    end
                    m_bits.delete();
                    done = 1'b1;
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_out_m = wm; m_out_l = wl; m_valid = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (clr)  m_ovf = 1'b0;
            if (drop) m_ovf = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0);
        n_tests++; if (p_valid_m !== 1'b0) begin n_fail++; $display("FAIL reset_p_valid got %b want 0", p_valid_m); end
        n_tests++; if (p_out_m !== 4'h0) begin n_fail++; $display("FAIL reset_p_out got %h want 0", p_out_m); end
        n_tests++; if (overflow_m !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow_m); end
        n_tests++; if (busy_m !== 1'b0 || busy_l !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0", busy_m, busy_l); end
    endtask

    task automatic test_basic_word();
        bit b[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, b[i], i == 0, 1, 0);
            if (i < 3) begin
                n_tests++; if (busy_m !== 1'b1 || p_valid_m !== 1'b0) begin n_fail++; $display("FAIL basic_busy bit%0d got busy=%b valid=%b want 1/0", i, busy_m, p_valid_m); end
            end
        end
        n_tests++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy_m); end
        n_tests++; if (p_valid_m !== 1'b1 || p_out_m !== 4'b1011) begin n_fail++; $display("FAIL basic_msb got valid=%b out=%b want 1/1011", p_valid_m, p_out_m); end
        n_tests++; if (p_valid_l !== 1'b1 || p_out_l !== 4'b1101) begin n_fail++; $display("FAIL basic_lsb got valid=%b out=%b want 1/1101", p_valid_l, p_out_l); end
        step(0, 0, 0, 0, 1, 0);
        n_tests++; if (p_valid_m !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle got valid=%b want 0", p_valid_m); end
    endtask

    task automatic test_overflow();
        bit a[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, a[i], i == 0, 0, 0);
        n_tests++; if (p_valid_m !== 1'b1 || p_out_m !== 4'hA || p_out_l !== 4'h5) begin n_fail++; $display("FAIL ovf_first got valid=%b out=%h/%h want 1/a/5", p_valid_m, p_out_m, p_out_l); end
        for (int i = 0; i < 4; i++) step(0, 1, ~a[i], 0, 0, 0);
        n_tests++; if (p_out_m !== 4'hA || overflow_m !== 1'b1 || overflow_l !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got out=%h ovf=%b/%b want a/1/1", p_out_m, overflow_m, overflow_l); end
        step(0, 0, 0, 0, 1, 0);
        n_tests++; if (p_valid_m !== 1'b0 || overflow_m !== 1'b1) begin n_fail++; $display("FAIL ovf_deliver got valid=%b ovf=%b want 0/1", p_valid_m, overflow_m); end
        step(0, 0, 0, 0, 0, 1);
        n_tests++; if (overflow_m !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", overflow_m); end
        // Fill the slot again, then drop a word on the same edge as a clear.
        for (int i = 0; i < 4; i++) step(0, 1, a[i], 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, a[i], 0, 0, 0);
        step(0, 1, a[3], 0, 0, 1);
        n_tests++; if (overflow_m !== 1'b1 || p_out_m !== 4'hA) begin n_fail++; $display("FAIL ovf_set_wins got ovf=%b out=%h want 1/a", overflow_m, p_out_m); end
    endtask

    task automatic test_back_to_back();
        bit w3[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        bit wc[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, w3[i], i == 0, 1, 0);
        n_tests++; if (p_valid_m !== 1'b1 || p_out_m !== 4'h3) begin n_fail++; $display("FAIL b2b_first got valid=%b out=%h want 1/3", p_valid_m, p_out_m); end
        for (int i = 0; i < 3; i++) step(0, 1, wc[i], 0, 0, 0);
        step(0, 1, wc[3], 0, 1, 0);
        n_tests++; if (p_valid_m !== 1'b1 || p_out_m !== 4'hC || overflow_m !== 1'b0) begin n_fail++; $display("FAIL b2b_second got valid=%b out=%h ovf=%b want 1/c/0", p_valid_m, p_out_m, overflow_m); end
        step(0, 0, 0, 0, 1, 0);
        n_tests++; if (p_valid_m !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got valid=%b want 0", p_valid_m); end
    endtask

    task automatic test_resync_gaps();
        bit b[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int words = 0;
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            int gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
                if (p_valid_m) words++;
            end
            step(0, 1, b[i], i == 2, 1, 0);
            if (p_valid_m) begin
                words++;
                n_tests++; if (p_out_m !== 4'h6) begin n_fail++; $display("FAIL resync_word got %h want 6", p_out_m); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 0);
            if (p_valid_m) words++;
        end
        n_tests++; if (words != 1 || overflow_m !== 1'b0) begin n_fail++; $display("FAIL resync_count got words=%0d ovf=%b want 1/0", words, overflow_m); end
    endtask

    task automatic test_reset_mid();
        bit b[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        n_tests++; if (busy_m !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy_m); end
        for (int i = 0; i < 4; i++) step(0, 1, b[i], 0, 0, 0);
        n_tests++; if (p_valid_m !== 1'b1 || p_out_m !== 4'h9) begin n_fail++; $display("FAIL rstmid_word got valid=%b out=%h want 1/9", p_valid_m, p_out_m); end
        step(1, 0, 0, 0, 0, 0);
        n_tests++; if (p_valid_m !== 1'b0 || p_out_m !== 4'h0) begin n_fail++; $display("FAIL rstmid_clear got valid=%b out=%h want 0/0", p_valid_m, p_out_m); end
    endtask

    task automatic test_random();
        step(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0);
            n_tests++;
            if (p_valid_m !== m_valid || p_out_m !== m_out_m || overflow_m !== m_ovf ||
                busy_m !== (m_bits.size() != 0) || p_valid_l !== m_valid || p_out_l !== m_out_l ||
                overflow_l !== m_ovf) begin
                n_fail++;
                $display("FAIL random cyc%0d got v=%b o=%h/%h ovf=%b busy=%b want v=%b o=%h/%h ovf=%b busy=%b",
                         n, p_valid_m, p_out_m, p_out_l, overflow_m, busy_m,
                         m_valid, m_out_m, m_out_l, m_ovf, m_bits.size() != 0);
            end
        end
    endtask

    initial begin
        m_out_m = '0; m_out_l = '0; m_valid = 1'b0; m_ovf = 1'b0;
        test_reset();
        test_basic_word();
        test_overflow();
        test_back_to_back();
        test_resync_gaps();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
